// File: rtl/hps_reset_seq_pkg.sv
// Shared types and default pulse widths for the HPS reset-request sequencer.
package hps_reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } tEResetSeqState;

  localparam int DEF_N_CH        = 3;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_PULSE_COLD  = 6;
  localparam int DEF_PULSE_WARM  = 2;
  localparam int DEF_PULSE_DEBUG = 32;
  localparam int DEF_GAP_CC      = 4;

endpackage

// File: rtl/hps_reset_req_chan.sv
// One request channel: edge detect on the request level, a single-entry
// pending flag and a sticky flag for edges lost while already pending.
module hps_reset_req_chan #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_in,
  input  logic clr_dropped,
  input  logic grant,
  output logic edge_det,
  output logic pending,
  output logic dropped
);

  logic hist;

  assign edge_det = RISE ? (req_in & ~hist) : (~req_in & hist);

  // hist tracks the input in reset too, so release never looks like an edge
  always_ff @(posedge clk) begin
    hist <= req_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      dropped <= 1'b0;
    end else begin
      if (grant) begin
        pending <= 1'b0;
      end else if (edge_det) begin
        pending <= 1'b1;
      end
      if (edge_det && pending) begin
        dropped <= 1'b1;
      end else if (clr_dropped) begin
        dropped <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hps_reset_req_sequencer.sv
// N-channel reset-request pulse generator: fixed-priority grant, one pulse
// at a time, a guard gap after every pulse.
//
// state | meaning
// IDLE  | no pulse in flight; grant lowest pending/edge channel
// PULSE | granted channel's pulse high, cnt counts down its length
// GAP   | outputs low, busy high, cnt counts down the guard gap
module hps_reset_req_sequencer
  import hps_reset_seq_pkg::*;
#(
  parameter int                         N_CH      = DEF_N_CH,
  parameter int                         CNT_W     = DEF_CNT_W,
  parameter logic [N_CH-1:0][CNT_W-1:0] PULSE_EXT = {CNT_W'(DEF_PULSE_DEBUG),
                                                     CNT_W'(DEF_PULSE_WARM),
                                                     CNT_W'(DEF_PULSE_COLD)},
  parameter logic [N_CH-1:0]            EDGE_TYPE = '1,
  parameter int                         GAP_CC    = DEF_GAP_CC,
  parameter bit                         IGNORE_RST_WHILE_BUSY = 1'b1
) (
  input  logic            ul1Clock,
  input  logic            ul1Reset_n,
  input  logic [N_CH-1:0] piulNReqIn,
  input  logic [N_CH-1:0] piulNClrDropped,
  output logic [N_CH-1:0] poulNPulse,
  output logic            poul1Busy,
  output logic [N_CH-1:0] poulNPending,
  output logic [N_CH-1:0] poulNDropped
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_PULSE = 2'(PULSE);
  localparam logic [1:0] S_GAP   = 2'(GAP);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CC > 0) ? CNT_W'(GAP_CC - 1) : '0;

  if (GAP_CC < 0 || GAP_CC > (2 ** CNT_W) - 1) begin : g_bad_gap
    $error("GAP_CC out of range for CNT_W");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  pulse;
  logic             busy;
  logic             rst_held;

  logic [N_CH-1:0]  edge_vec;
  logic [N_CH-1:0]  pending_vec;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  grant_pick;
  logic [N_CH-1:0]  grant;
  logic [CNT_W-1:0] load_cnt;
  logic             req_any;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    if (PULSE_EXT[i] == '0) begin : g_bad_pulse
      $error("PULSE_EXT entry must be nonzero");
    end

    hps_reset_req_chan #(
      .RISE (EDGE_TYPE[i])
    ) u_chan (
      .clk         (ul1Clock),
      .rst_n       (ul1Reset_n),
      .req_in      (piulNReqIn[i]),
      .clr_dropped (piulNClrDropped[i]),
      .grant       (grant[i]),
      .edge_det    (edge_vec[i]),
      .pending     (pending_vec[i]),
      .dropped     (poulNDropped[i])
    );
  end

  assign req     = pending_vec | edge_vec;
  assign req_any = |req;

  // descending scan so the lowest set index is the last to overwrite
  always_comb begin
    grant_pick = '0;
    load_cnt   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_pick    = '0;
        grant_pick[i] = 1'b1;
        load_cnt      = PULSE_EXT[i] - CNT_ONE;
      end
    end
  end

  assign grant = (state == S_IDLE) ? grant_pick : '0;

  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset_n && !(IGNORE_RST_WHILE_BUSY && state == S_PULSE)) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pulse    <= '0;
      busy     <= 1'b0;
      rst_held <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            state <= S_PULSE;
            cnt   <= load_cnt;
            pulse <= grant_pick;
            busy  <= 1'b1;
          end
        end
        S_PULSE: begin
          // a reset seen during the pulse means no gap afterwards
          if (!ul1Reset_n) begin
            rst_held <= 1'b1;
          end
          if (cnt == '0) begin
            pulse    <= '0;
            rst_held <= 1'b0;
            if (GAP_CC == 0 || rst_held || !ul1Reset_n) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          pulse    <= '0;
          busy     <= 1'b0;
          rst_held <= 1'b0;
        end
      endcase
    end
  end

  assign poulNPulse   = pulse;
  assign poul1Busy    = busy;
  assign poulNPending = pending_vec;

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Self-checking bench: two sequencer instances (default, and no-reset-ignore
// with ch1 falling-edge) checked every cycle against a timeline model.
module tb_hps_reset_req_sequencer;

  localparam int GAP = 4;
  localparam int P_EXT [3] = '{6, 2, 32};

  typedef struct packed {
    int         pulse_left;
    int         gap_left;
    int         active;
    logic       skip;
    logic [2:0] hist;
    logic [2:0] pending;
    logic [2:0] dropped;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] clr;

  logic [2:0] pulse_a, pend_a, drop_a;
  logic       busy_a;
  logic [2:0] pulse_b, pend_b, drop_b;
  logic       busy_b;

  mdl_t m_a = '0;
  mdl_t m_b = '0;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hps_reset_req_sequencer dut_a (
    .ul1Clock        (clk),
    .ul1Reset_n      (rst_n),
    .piulNReqIn      (req),
    .piulNClrDropped (clr),
    .poulNPulse      (pulse_a),
    .poul1Busy       (busy_a),
    .poulNPending    (pend_a),
    .poulNDropped    (drop_a)
  );

  hps_reset_req_sequencer #(
    .EDGE_TYPE             (3'b101),
    .IGNORE_RST_WHILE_BUSY (1'b0)
  ) dut_b (
    .ul1Clock        (clk),
    .ul1Reset_n      (rst_n),
    .piulNReqIn      (req),
    .piulNClrDropped (clr),
    .poulNPulse      (pulse_b),
    .poul1Busy       (busy_b),
    .poulNPending    (pend_b),
    .poulNDropped    (drop_b)
  );

  // One clock of the request/pulse timeline: remaining pulse and gap cycles
  // are plain counts, grants go to the lowest requesting channel.
  function automatic mdl_t mstep(mdl_t m, logic rn, logic [2:0] in, logic [2:0] cl,
                                 logic [2:0] et, bit ign);
    mdl_t       n = m;
    logic [2:0] ev;
    logic [2:0] rq;
    logic [2:0] gnt = 3'b000;
    int         idx = -1;
    ev = (in & ~m.hist & et) | (~in & m.hist & ~et);
    n.hist = in;
    if (!rn && !(ign && m.pulse_left > 0)) begin
      n.pulse_left = 0;
      n.gap_left   = 0;
      n.skip       = 1'b0;
      n.pending    = 3'b000;
      n.dropped    = 3'b000;
      return n;
    end
    if (!rn) begin
      n.pending = 3'b000;
      n.dropped = 3'b000;
      n.skip    = 1'b1;
    end else begin
      rq = m.pending | ev;
      if (m.pulse_left == 0 && m.gap_left == 0) begin
        for (int i = 2; i >= 0; i--) if (rq[i]) idx = i;
        if (idx >= 0) gnt = 3'(1 << idx);
      end
      n.dropped = (ev & m.pending) | (m.dropped & ~cl);
      n.pending = (m.pending | ev) & ~gnt;
    end
    if (idx >= 0) begin
      n.active     = idx;
      n.pulse_left = P_EXT[idx];
    end else if (m.pulse_left > 0) begin
      n.pulse_left = m.pulse_left - 1;
      if (n.pulse_left == 0) begin
        n.gap_left = n.skip ? 0 : GAP;
        n.skip     = 1'b0;
      end
    end else if (m.gap_left > 0) begin
      n.gap_left = m.gap_left - 1;
    end
    return n;
  endfunction

  function automatic logic [2:0] exp_pulse(mdl_t m);
    return (m.pulse_left > 0) ? 3'(1 << m.active) : 3'b000;
  endfunction

  function automatic logic exp_busy(mdl_t m);
    return (m.pulse_left > 0) || (m.gap_left > 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    m_a <= mstep(m_a, rst_n, req, clr, 3'b111, 1'b1);
    m_b <= mstep(m_b, rst_n, req, clr, 3'b101, 1'b0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_pulse",   32'(pulse_a), 32'(exp_pulse(m_a)));
      check("a_busy",    32'(busy_a),  32'(exp_busy(m_a)));
      check("a_pending", 32'(pend_a),  32'(m_a.pending));
      check("a_dropped", 32'(drop_a),  32'(m_a.dropped));
      check("b_pulse",   32'(pulse_b), 32'(exp_pulse(m_b)));
      check("b_busy",    32'(busy_b),  32'(exp_busy(m_b)));
      check("b_pending", 32'(pend_b),  32'(m_b.pending));
      check("b_dropped", 32'(drop_b),  32'(m_b.dropped));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n2;
    rst_n = 1'b0;
    req   = 3'b111;
    clr   = 3'b000;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_pulse", 32'(pulse_a), 32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);

    // release with all requests held high: nothing may fire
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("rel_pulse", 32'(pulse_a), 32'h0);
      check("rel_pend",  32'(pend_a),  32'h0);
    end
    rst_n = 1'b0;
    req   = 3'b000;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // ch1 rise: 2-cycle pulse, busy 6 cycles; dut_b ignores the rise
    req = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("ch1_pulse", 32'(pulse_a), (k <= 2) ? 32'h2 : 32'h0);
      check("ch1_busy",  32'(busy_a),  (k <= 6) ? 32'h1 : 32'h0);
      check("b_rise_nopulse", 32'(pulse_b), 32'h0);
    end
    tick(3);

    // ch1 fall: dut_b fires its 2-cycle pulse
    req = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("b_fall_pulse", 32'(pulse_b), (k <= 2) ? 32'h2 : 32'h0);
      check("b_fall_busy",  32'(busy_b),  (k <= 6) ? 32'h1 : 32'h0);
    end
    tick(3);

    // ch0 and ch2 together: ch0 first, ch2 after the gap
    req = 3'b101;
    for (int k = 1; k <= 48; k++) begin
      tick(1);
      if (k <= 6) begin
        check("sim_ch0_pulse", 32'(pulse_a), 32'h1);
        check("sim_pend",      32'(pend_a),  32'h4);
      end
      if (k == 7) check("sim_gap_busy", 32'(busy_a), 32'h1);
      if (k == 12 || k == 43) check("sim_ch2_pulse", 32'(pulse_a), 32'h4);
      if (k == 44) check("sim_ch2_end", 32'(pulse_a), 32'h0);
    end
    tick(2);
    req = 3'b000;
    tick(2);

    // ch2 toggles during ch0 pulse: one queued, one dropped
    req = 3'b001; tick(1);
    req = 3'b101; tick(1);
    check("tog_pend", 32'(pend_a), 32'h4);
    req = 3'b001; tick(1);
    req = 3'b101; tick(1);
    check("tog_drop", 32'(drop_a), 32'h4);
    clr = 3'b100; tick(1);
    clr = 3'b000;
    check("tog_clr", 32'(drop_a), 32'h0);
    n2 = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      if (pulse_a[2]) n2++;
    end
    check("tog_single_ch2", 32'(n2), 32'd32);

    // clear and a new drop in the same cycle: the drop wins
    req = 3'b000; tick(2);
    req = 3'b001; tick(1);
    req = 3'b101; tick(1);
    req = 3'b001; tick(1);
    req = 3'b101; clr = 3'b100; tick(1);
    clr = 3'b000;
    check("set_wins", 32'(drop_a), 32'h4);
    clr = 3'b100; tick(1);
    clr = 3'b000;
    check("clr_after", 32'(drop_a), 32'h0);
    tick(60);

    // reset during cycle 3 of ch2's pulse
    req = 3'b000; tick(2);
    req = 3'b100; tick(3);
    rst_n = 1'b0;
    tick(1);
    check("b_rst_kill",  32'(pulse_b), 32'h0);
    check("a_rst_keep",  32'(pulse_a), 32'h4);
    check("a_rst_busy",  32'(busy_a),  32'h1);
    tick(4);
    rst_n = 1'b1;
    for (int k = 9; k <= 34; k++) begin
      tick(1);
      if (k == 32) check("a_rst_last", 32'(pulse_a), 32'h4);
      if (k == 33) begin
        check("a_rst_end",    32'(pulse_a), 32'h0);
        check("a_rst_nogap",  32'(busy_a),  32'h0);
        check("a_rst_nopend", 32'(pend_a),  32'h0);
      end
    end
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
